// File: rtl/debounce_pkg.sv
// Shared types and defaults for the button debouncer.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO,
        PEND_HI,
        STABLE_HI,
        PEND_LO
    } chan_state_e;

    localparam int WIDTH_DEF         = 3;
    localparam int STABLE_CYCLES_DEF = 65536;

endpackage

// File: rtl/button_debounce_if.sv
// Button bundle: raw buttons toward the debouncer, debounced results back.
interface button_debounce_if #(
    parameter int W = 3
);

    logic [W-1:0] button;
    logic [W-1:0] level;
    logic [W-1:0] press;
    logic [W-1:0] rel;

    modport master (
        output button,
        input  level,
        input  press,
        input  rel
    );

    modport slave (
        input  button,
        output level,
        output press,
        output rel
    );

endinterface

// File: rtl/debounce_chan.sv
// One debounced button channel: 2-flop synchronizer, then a 4-state
// pending/stable FSM with registered level and edge pulses.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic i_button,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] TERM = CW'(STABLE_CYCLES - 1);

    logic [1:0]    r_sync;
    logic          w_sample;
    chan_state_e   r_state;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_press;
    logic          r_release;

    assign w_sample = r_sync[1];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_button};
        end
    end

    // Entering a pending state already counts the first differing sample.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state   <= STABLE_LO;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            unique case (r_state)
                STABLE_LO: begin
                    if (w_sample) begin
                        r_state <= PEND_HI;
                        r_cnt   <= CW'(1);
                    end
                end
                STABLE_HI: begin
                    if (!w_sample) begin
                        r_state <= PEND_LO;
                        r_cnt   <= CW'(1);
                    end
                end
                PEND_HI: begin
                    if (!w_sample) begin
                        r_state <= STABLE_LO;
                        r_cnt   <= '0;
                    end else if (r_cnt == TERM) begin
                        r_state <= STABLE_HI;
                        r_cnt   <= '0;
                        r_level <= 1'b1;
                        r_press <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                PEND_LO: begin
                    if (w_sample) begin
                        r_state <= STABLE_HI;
                        r_cnt   <= '0;
                    end else if (r_cnt == TERM) begin
                        r_state   <= STABLE_LO;
                        r_cnt     <= '0;
                        r_level   <= 1'b0;
                        r_release <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= STABLE_LO;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/button_debounce.sv
// Multi-channel button debouncer; each channel is fully independent.
module button_debounce
    import debounce_pkg::*;
#(
    parameter int width_p         = WIDTH_DEF,
    parameter int stable_cycles_p = STABLE_CYCLES_DEF
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] button_async_unsafe_i,
    output logic [width_p-1:0] level_o,
    output logic [width_p-1:0] press_o,
    output logic [width_p-1:0] release_o
);

    for (genvar g = 0; g < width_p; g++) begin : g_chan
        debounce_chan #(
            .STABLE_CYCLES(stable_cycles_p)
        ) u_chan (
            .clk_i    (clk_i),
            .reset_n_i(reset_n_i),
            .i_button (button_async_unsafe_i[g]),
            .o_level  (level_o[g]),
            .o_press  (press_o[g]),
            .o_release(release_o[g])
        );
    end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with stable_cycles_p = 4, width_p = 3.
module tb_button_debounce;

    logic clk_i = 1'b0;
    logic reset_n_i = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_press1 = 0;

    button_debounce_if #(.W(3)) bus ();

    button_debounce #(
        .width_p        (3),
        .stable_cycles_p(4)
    ) dut (
        .clk_i                (clk_i),
        .reset_n_i            (reset_n_i),
        .button_async_unsafe_i(bus.button),
        .level_o              (bus.level),
        .press_o              (bus.press),
        .release_o            (bus.rel)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (bus.press[1]) n_press1 = n_press1 + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [2:0] obs,
                       input logic [2:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [2:0] lv,
                        input logic [2:0] pr, input logic [2:0] rl);
        chk({tag, ".level"}, bus.level, lv);
        chk({tag, ".press"}, bus.press, pr);
        chk({tag, ".release"}, bus.rel, rl);
    endtask

    initial begin
        bus.button = 3'b000;
        tick(3);
        chk3("reset", 3'b000, 3'b000, 3'b000);
        reset_n_i = 1'b1;
        tick(3);
        chk3("idle", 3'b000, 3'b000, 3'b000);

        // clean press on bit0
        bus.button = 3'b001;
        tick(5);
        chk3("press0_early", 3'b000, 3'b000, 3'b000);
        tick(1);
        chk3("press0", 3'b001, 3'b001, 3'b000);
        tick(1);
        chk3("press0_after", 3'b001, 3'b000, 3'b000);

        // bounce on bit1: 1,0,1,1,0 then steady 1
        n_press1 = 0;
        bus.button = 3'b011; tick(1);
        bus.button = 3'b001; tick(1);
        bus.button = 3'b011; tick(1);
        bus.button = 3'b011; tick(1);
        bus.button = 3'b001; tick(1);
        bus.button = 3'b011;
        tick(5);
        chk3("bounce_early", 3'b001, 3'b000, 3'b000);
        tick(1);
        chk3("bounce", 3'b011, 3'b010, 3'b000);
        tick(3);
        chk3("bounce_after", 3'b011, 3'b000, 3'b000);
        chk("bounce_pulses", 3'(n_press1), 3'd1);

        // bits0/1 release while bit2 presses at the same edge
        bus.button = 3'b100;
        tick(5);
        chk3("swap_early", 3'b011, 3'b000, 3'b000);
        tick(1);
        chk3("swap", 3'b100, 3'b100, 3'b011);
        tick(1);

        // release from level 100
        bus.button = 3'b000;
        tick(5);
        chk3("release2_early", 3'b100, 3'b000, 3'b000);
        tick(1);
        chk3("release2", 3'b000, 3'b000, 3'b100);
        tick(1);
        chk3("release2_after", 3'b000, 3'b000, 3'b000);

        // simultaneous press and release of bits 0 and 2
        bus.button = 3'b101;
        tick(6);
        chk3("simul_press", 3'b101, 3'b101, 3'b000);
        tick(1);
        bus.button = 3'b000;
        tick(6);
        chk3("simul_release", 3'b000, 3'b000, 3'b101);
        tick(1);

        // reset while bit0 is pending, bit2 level high
        bus.button = 3'b100;
        tick(7);
        chk3("pre_reset", 3'b100, 3'b000, 3'b000);
        bus.button = 3'b101;
        tick(3);
        reset_n_i = 1'b0;
        #1;
        chk3("mid_reset", 3'b000, 3'b000, 3'b000);
        tick(2);
        chk3("in_reset", 3'b000, 3'b000, 3'b000);
        reset_n_i = 1'b1;
        tick(5);
        chk3("post_reset_early", 3'b000, 3'b000, 3'b000);
        tick(1);
        chk3("post_reset", 3'b101, 3'b101, 3'b000);
        tick(1);

        // 3-cycle glitch on bit1 must be ignored
        n_press1 = 0;
        bus.button = 3'b111;
        tick(3);
        bus.button = 3'b101;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk3("glitch", 3'b101, 3'b000, 3'b000);
        end
        chk("glitch_pulses", 3'(n_press1), 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 SHALL have parameter width_p, default 3, number of independent button channels.
REQ-002 SHALL have parameter stable_cycles_p, default 65536, consecutive stable clock cycles needed to accept a new button level; legal range >= 2.
REQ-003 SHALL have port clk_i  input  1  single rising-edge clock; all flops on this clock.
REQ-004 SHALL have port reset_n_i  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port button_async_unsafe_i  input  width_p  raw buttons, active-high, unsynchronized, bouncing.
REQ-006 SHALL have port level_o  output  width_p  debounced level per channel, 1 = pressed.
REQ-007 SHALL have port press_o  output  width_p  one-cycle pulse per channel on accepted 0->1 of level_o.
REQ-008 SHALL have port release_o  output  width_p  one-cycle pulse per channel on accepted 1->0 of level_o.

Function
REQ-009 SHALL process each channel independently; no cross-channel interaction.
REQ-010 SHALL pass each input bit through a two-flop synchronizer; only the second-flop value (synced sample) feeds later logic.
REQ-011 SHALL run a per-channel FSM with states STABLE_LO, PEND_HI, STABLE_HI, PEND_LO.
REQ-012 SHALL transition: STABLE_LO -> PEND_HI when synced=1; STABLE_HI -> PEND_LO when synced=0; otherwise stay.
REQ-013 SHALL, in PEND_x, increment a per-channel counter each cycle the synced sample still differs from level_o.
REQ-014 SHALL return PEND_HI -> STABLE_LO (PEND_LO -> STABLE_HI) and clear the counter on any cycle the synced sample equals level_o (bounce), with no output change.
REQ-015 SHALL, when counter = stable_cycles_p-1 and the sample still differs, flip level_o, enter the matching STABLE_x state, clear the counter, and pulse press_o/release_o at that same edge.
REQ-016 SHALL make total latency exactly: input constant from before edge E0 -> level_o and pulse change at edge E0+stable_cycles_p+1.
REQ-017 SHALL hold press_o/release_o high exactly one cycle per accepted transition; never both high on one channel in the same cycle.
REQ-018 SHALL size the counter $clog2(stable_cycles_p) bits; counter never wraps (cleared at terminal value).
REQ-019 SHALL ignore any glitch shorter than stable_cycles_p cycles at the synced sample.
REQ-020 SHALL restart counting from 0 if the sample differs again after a bounce (no credit for earlier partial counts).

Reset
REQ-021 SHALL, while reset_n_i = 0, asynchronously clear synchronizer flops, counters, level_o, press_o, release_o to 0 and force state STABLE_LO.
REQ-022 SHALL, if a button is held through reset deassertion, report it as a normal press after REQ-016 latency measured from the first post-reset edge.
REQ-023 SHALL, on reset asserted mid-pending, discard the partial count; no pulse emitted.

Structure
REQ-024 SHALL place the channel-state typedef (4-state enum) and default constants (width_p, stable_cycles_p) in shared package debounce_pkg.
REQ-025 SHALL implement one channel in sub-module debounce_chan, instantiated width_p times by a generate loop in button_debounce.
REQ-026 SHALL contain no combinational path from button_async_unsafe_i to any output.

Verification (stable_cycles_p = 4, width_p = 3)
REQ-027 SHALL cover clean press: bit0 0->1 before edge E0, held -> level_o[0]=1 and press_o=3'b001 for one cycle at E0+5; other bits stay 0.
REQ-028 SHALL cover bounce: bit1 pattern 1,0,1,1,0 then steady 1 -> level_o[1] rises only 5 edges after the final 0->1; exactly one press_o[1] pulse.
REQ-029 SHALL cover release: from level_o=3'b100, bit2 -> 0 before E0 -> release_o=3'b100 one cycle at E0+5, level_o=0.
REQ-030 SHALL cover simultaneous: bits0 and 2 rise same cycle -> press_o=3'b101 in one cycle at E0+5.
REQ-031 SHALL cover reset mid-pending: reset_n_i low 2 cycles after bit0 rises -> all outputs 0 immediately; after release with bit0 still high, press_o[0] at first post-reset edge +5.
REQ-032 SHALL cover 3-cycle glitch: bit1 high 3 cycles then low -> no pulse, level_o unchanged.
